alu_issue_ctrl: RTL and testbench

- Initiator side of the ALU operand/control interface: accepts one instruction word plus its two register read values, decodes the opcode into the 4-bit ALU_Control code, and drives ALU_Control, inA, inB and changeROM into the combinational ALU.
- Holds operands stable for a per-operation number of cycles so the slow div/mult paths settle, captures result/zero, and returns them with a destination register address over a valid/ready handshake.
- Sits between the register-read stage and writeback.

---
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one instruction, drives the combinational ALU,
// holds its operands for a per-op number of cycles, then returns the
// captured result over a valid/ready handshake.
module alu_issue_ctrl #(
  parameter int DIV_CYCLES = 8,
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_clr,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic [4:0]  out_waddr,
  output logic        out_illegal
);

  localparam int MAXH = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW   = ($clog2(MAXH) < 1) ? 1 : $clog2(MAXH);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
  localparam logic [3:0]    CTRL_IDLE = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [5:0]    opc;
  logic          dec_legal;
  logic          dec_imm;
  logic [3:0]    dec_ctrl;
  logic [CW-1:0] dec_ld;
  logic [31:0]   dec_b;
  logic [4:0]    dec_waddr;
  logic          accept;
  // rs field is carried only for the register file; the value arrives on rs_data
  logic          unused_rs;

  assign opc       = instr[31:26];
  assign unused_rs = ^instr[25:21];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready & ~flush;

  // Opcode decode into ALU control code, operand B source and hold length
  always_comb begin
    dec_legal = 1'b1;
    dec_imm   = 1'b0;
    dec_ctrl  = CTRL_IDLE;
    dec_ld    = '0;
    unique case (opc)
      6'h01: begin dec_ctrl = 4'b0000; dec_ld = DIV_LD; end
      6'h02: begin dec_ctrl = 4'b0001; dec_ld = MUL_LD; end
      6'h03: dec_ctrl = 4'b0010;
      6'h04: dec_ctrl = 4'b0011;
      6'h05: dec_ctrl = 4'b0100;
      6'h06: dec_ctrl = 4'b0101;
      6'h07: dec_ctrl = 4'b0110;
      6'h08: dec_ctrl = 4'b0111;
      6'h09: dec_ctrl = 4'b1000;
      6'h0A: dec_ctrl = 4'b1001;
      6'h0B: dec_ctrl = 4'b1010;
      6'h0C: dec_ctrl = 4'b1011;
      6'h10: begin dec_ctrl = 4'b0011; dec_imm = 1'b1; end
      6'h11: begin dec_ctrl = 4'b0010; dec_imm = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_b     = dec_imm ? {{16{instr[15]}}, instr[15:0]} : rt_data;
  assign dec_waddr = dec_imm ? instr[20:16] : instr[15:11];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: flush always returns to IDLE; illegal ops skip EXEC
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_nxt = dec_legal ? EXEC : DONE;
        EXEC:    if (cnt == '0) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ALU drive, hold counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ctrl    <= CTRL_IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_clr     <= 1'b0;
      cnt         <= '0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_waddr   <= '0;
      out_illegal <= 1'b0;
    end else begin
      alu_clr <= flush;
      if (flush) begin
        alu_ctrl <= CTRL_IDLE;
        alu_a    <= '0;
        alu_b    <= '0;
        cnt      <= '0;
      end else begin
        unique case (state)
          IDLE: if (accept) begin
            if (dec_legal) begin
              alu_ctrl  <= dec_ctrl;
              alu_a     <= rs_data;
              alu_b     <= dec_b;
              out_waddr <= dec_waddr;
              cnt       <= dec_ld;
            end else begin
              out_result  <= '0;
              out_zero    <= 1'b1;
              out_illegal <= 1'b1;
              out_waddr   <= '0;
            end
          end
          EXEC: begin
            if (cnt == '0) begin
              out_result  <= alu_result;
              out_zero    <= alu_zero;
              out_illegal <= 1'b0;
              alu_ctrl    <= CTRL_IDLE;
              alu_a       <= '0;
              alu_b       <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl with a stand-in combinational ALU and
// a transaction-level reference model derived from opcode semantics.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, alu_clr, alu_zero;
  logic        out_valid, out_ready, out_zero, out_illegal;
  logic [31:0] instr, rs_data, rt_data, alu_a, alu_b, alu_result, out_result;
  logic [3:0]  alu_ctrl;
  logic [4:0]  out_waddr;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DIV_CYCLES(8), .MUL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_clr(alu_clr),
    .alu_result(alu_result), .alu_zero(alu_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_waddr(out_waddr), .out_illegal(out_illegal)
  );

  // Stand-in ALU keyed by ALU_Control code
  always_comb begin
    alu_result = '0;
    if (!alu_clr) begin
      case (alu_ctrl)
        4'b0000: alu_result = (alu_b == 0) ? 32'hDEAD_BEEF : alu_a / alu_b;
        4'b0001: alu_result = alu_a * alu_b;
        4'b0010: alu_result = alu_a - alu_b;
        4'b0011: alu_result = alu_a + alu_b;
        4'b0100: alu_result = alu_a | alu_b;
        4'b0101: alu_result = alu_a & alu_b;
        4'b0110: alu_result = {31'd0, alu_a <  alu_b};
        4'b0111: alu_result = {31'd0, alu_a <= alu_b};
        4'b1000: alu_result = {31'd0, alu_a >  alu_b};
        4'b1001: alu_result = {31'd0, alu_a >= alu_b};
        4'b1010: alu_result = {31'd0, alu_a == alu_b};
        4'b1011: alu_result = {31'd0, alu_a != alu_b};
        default: alu_result = '0;
      endcase
    end
    alu_zero = (alu_result == 0);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Reference model: opcode-level semantics
  function automatic bit m_legal(input logic [5:0] op);
    return (op >= 6'h01 && op <= 6'h0C) || op == 6'h10 || op == 6'h11;
  endfunction

  function automatic int m_hold(input logic [5:0] op);
    return (op == 6'h01) ? 8 : (op == 6'h02) ? 4 : 1;
  endfunction

  function automatic logic [3:0] m_code(input logic [5:0] op);
    logic [3:0] tbl [0:17];
    tbl = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
            4'h9, 4'hA, 4'hB, 4'hF, 4'hF, 4'hF, 4'h3, 4'h2};
    return (op <= 6'h11) ? tbl[op] : 4'hF;
  endfunction

  function automatic logic [31:0] m_b(input logic [31:0] ins, input logic [31:0] rt);
    logic [31:0] sx;
    sx = {{16{ins[15]}}, ins[15:0]};
    return (ins[31:26] >= 6'h10) ? sx : rt;
  endfunction

  function automatic logic [31:0] m_res(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      6'h01: return a / b;
      6'h02: return a * b;
      6'h03, 6'h11: return a - b;
      6'h04, 6'h10: return a + b;
      6'h05: return a | b;
      6'h06: return a & b;
      6'h07: return (a <  b) ? 1 : 0;
      6'h08: return (a <= b) ? 1 : 0;
      6'h09: return (a >  b) ? 1 : 0;
      6'h0A: return (a >= b) ? 1 : 0;
      6'h0B: return (a == b) ? 1 : 0;
      6'h0C: return (a != b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'hF);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_clr"}, 32'(alu_clr), 0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_out_zero"}, 32'(out_zero), 0);
    chk({tag, "_out_waddr"}, 32'(out_waddr), 0);
    chk({tag, "_out_illegal"}, 32'(out_illegal), 0);
  endtask

  // One transaction; bp = cycles of backpressure in DONE; rst_done resets in DONE
  task automatic run_op(input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] rt, input int bp, input bit rst_done);
    logic [5:0]  op;
    logic [31:0] b, er;
    int          lat;
    bit          leg;
    op  = ins[31:26];
    leg = m_legal(op);
    b   = m_b(ins, rt);
    er  = leg ? m_res(op, a, b) : 32'd0;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 1);
    in_valid = 1'b1; instr = ins; rs_data = a; rt_data = rt; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; rs_data = $urandom; rt_data = $urandom; instr = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("exec_ready", 32'(in_ready), 0);
      chk("exec_ctrl", 32'(alu_ctrl), 32'(m_code(op)));
      chk("exec_a", alu_a, a);
      chk("exec_b", alu_b, b);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, leg ? m_hold(op) : 0);
    for (int i = 0; i <= bp; i++) begin
      if (i == bp) out_ready = 1'b1;
      chk("done_valid", 32'(out_valid), 1);
      chk("done_ready", 32'(in_ready), 0);
      chk("done_result", out_result, er);
      chk("done_zero", 32'(out_zero), 32'(er == 0));
      chk("done_waddr", 32'(out_waddr), leg ? 32'(op >= 6'h10 ? ins[20:16] : ins[15:11]) : 0);
      chk("done_illegal", 32'(out_illegal), 32'(!leg));
      chk("done_ctrl", 32'(alu_ctrl), 32'hF);
      if (rst_done && i == bp) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        chk_reset("rst_done");
        return;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("hs_valid", 32'(out_valid), 0);
    chk("hs_ready", 32'(in_ready), 1);
  endtask

  initial begin
    logic [5:0]  legal_ops [0:13];
    logic [5:0]  op;
    logic [31:0] ins, a, rt;
    legal_ops = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                  6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h10, 6'h11};
    rst = 1'b1; in_valid = 1'b1; instr = 32'h1000_0000; rs_data = 0; rt_data = 0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk_reset("reset");

    // Directed cases
    run_op({6'h04, 5'd1, 5'd2, 5'd3, 11'd0}, 7, 5, 0, 0);
    run_op({6'h10, 5'd1, 5'd9, 16'hFFFF}, 2, 0, 0, 0);
    run_op({6'h01, 5'd1, 5'd2, 5'd4, 11'd0}, 100, 7, 0, 0);
    run_op({6'h03, 5'd1, 5'd2, 5'd6, 11'd0}, 5, 5, 4, 0);
    run_op({6'h3F, 26'h155_5555}, 1, 2, 1, 0);

    // Flush during mult when the hold counter reads 2
    @(negedge clk);
    in_valid = 1'b1; instr = {6'h02, 5'd1, 5'd2, 5'd7, 11'd0}; rs_data = 3; rt_data = 9;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 32'(in_ready), 1);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_clr", 32'(alu_clr), 1);
    chk("flush_ctrl", 32'(alu_ctrl), 32'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_clr_off", 32'(alu_clr), 0);
      chk("flush_novalid", 32'(out_valid), 0);
    end

    // Flush beats a simultaneous accept
    in_valid = 1'b1; flush = 1'b1; instr = {6'h04, 26'd0};
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_acc_ready", 32'(in_ready), 1);
    chk("flush_acc_clr", 32'(alu_clr), 1);
    chk("flush_acc_ctrl", 32'(alu_ctrl), 32'hF);
    repeat (3) begin
      @(negedge clk);
      chk("flush_acc_novalid", 32'(out_valid), 0);
    end

    // Flush in DONE discards the result
    @(negedge clk);
    in_valid = 1'b1; instr = {6'h05, 5'd0, 5'd0, 5'd1, 11'd0}; rs_data = 1; rt_data = 2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_flush_valid", 32'(out_valid), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_valid", 32'(out_valid), 0);
    chk("flush_done_ready", 32'(in_ready), 1);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(18, 63))
                                       : legal_ops[$urandom_range(0, 13)];
      ins = {op, 26'($urandom)};
      a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rt  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (op == 6'h01 && rt == 0) rt = 3;
      run_op(ins, a, rt, $urandom_range(0, 3), 0);
    end

    // Reset while a result is pending
    run_op({6'h04, 5'd1, 5'd2, 5'd8, 11'd0}, 10, 20, 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
